// File: rtl/ex_mdu.sv
// ex_mdu: RISC-V execute stage covering RV32I ALU ops and RV32M mul/div.
//   ALU ops produce a registered result one cycle after acceptance and can
//   issue back to back. MUL/DIV ops run on an iterative radix-2 engine.
//   One iteration is done per cycle for XLEN cycles. The engine holds
//   ready_o low until the result pulses out.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_i         abort in-flight op; a same-cycle valid_i is dropped
//   valid_i/ready_o handshake; ready_o is high only when IDLE
//   op_i            5-bit opcode (0..9 ALU, 16..23 MUL/DIV, others = ADD)
//   reg1_i, reg2_i  operands
//   wd_i, wreg_i    destination register and write request
//   valid_o         one-cycle result strobe
//   wd_o, wreg_o    destination and write enable (x0 never written)
//   wdata_o         result
module ex_mdu #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [4:0]            op_i,
  input  logic [XLEN-1:0]       reg1_i,
  input  logic [XLEN-1:0]       reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [XLEN-1:0]       wdata_o
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3,
                         OP_SLTU = 5'd4, OP_XOR = 5'd5, OP_SRL = 5'd6,
                         OP_SRA = 5'd7, OP_OR = 5'd8, OP_AND = 5'd9;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Latched mul/div request; fn = op_i[2:0]
  // (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
  typedef struct packed {
    logic [2:0]            fn;
    logic                  sa;   // rs1 negative (signed view only)
    logic                  sb;   // rs2 negative (signed view only)
    logic                  bz;   // divisor zero
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
  } md_req_t;

  state_t          state;
  md_req_t         req;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] hi, lo, dvs;

  assign ready_o = (state == IDLE);

  // ---------------- ALU ----------------
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  assign shamt = reg2_i[SHW-1:0];

  always_comb begin
    alu_res = reg1_i + reg2_i;
    case (op_i)
      OP_SUB:  alu_res = reg1_i - reg2_i;
      OP_SLL:  alu_res = reg1_i << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, reg1_i < reg2_i};
      OP_XOR:  alu_res = reg1_i ^ reg2_i;
      OP_SRL:  alu_res = reg1_i >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(reg1_i) >>> shamt);
      OP_OR:   alu_res = reg1_i | reg2_i;
      OP_AND:  alu_res = reg1_i & reg2_i;
      default: alu_res = reg1_i + reg2_i;
    endcase
  end

  // ---------------- mul/div operand setup ----------------
  logic            is_md, is_div, a_sgn, b_sgn, sa_in, sb_in;
  logic [XLEN-1:0] mag_a, mag_b;
  assign is_md  = (op_i[4:3] == 2'b10);
  assign is_div = op_i[2];
  // rs1 signed for MULH, MULHSU, DIV, REM; rs2 signed for MULH, DIV, REM.
  assign a_sgn  = (op_i[2:0] == 3'd1) || (op_i[2:0] == 3'd2) ||
                  (op_i[2:0] == 3'd4) || (op_i[2:0] == 3'd6);
  assign b_sgn  = (op_i[2:0] == 3'd1) || (op_i[2:0] == 3'd4) ||
                  (op_i[2:0] == 3'd6);
  assign sa_in  = a_sgn && reg1_i[XLEN-1];
  assign sb_in  = b_sgn && reg2_i[XLEN-1];
  assign mag_a  = sa_in ? -reg1_i : reg1_i;
  assign mag_b  = sb_in ? -reg2_i : reg2_i;

  // ---------------- iteration step ----------------
  // Multiply: {hi,lo} starts as {0, multiplier}; add multiplicand into hi
  // when lo[0] is set, then shift the whole thing right by one.
  // Divide: lo starts as the dividend and fills with quotient bits from the
  // right while hi accumulates the partial remainder (restoring).
  logic [XLEN:0]   sum, rem_sh, diff;
  logic [XLEN-1:0] hi_nx, lo_nx;

  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    rem_sh = {hi, lo[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs};
    if (req.fn[2]) begin
      if (!diff[XLEN]) begin
        hi_nx = diff[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = rem_sh[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = sum[XLEN:1];
      lo_nx = {sum[0], lo[XLEN-1:1]};
    end
  end

  // ---------------- result fixup ----------------
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem, md_res;

  always_comb begin
    prod_s = (req.sa ^ req.sb) ? -{hi, lo} : {hi, lo};
    // Divide by zero yields all-ones regardless of the dividend sign.
    quo    = req.bz ? '1 : ((req.sa ^ req.sb) ? -lo : lo);
    rem    = req.sa ? -hi : hi;
    case (req.fn)
      3'd0:          md_res = prod_s[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          md_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:    md_res = quo;
      default:       md_res = rem;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      wreg_o  <= 1'b0;
      wd_o    <= '0;
      wdata_o <= '0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      dvs     <= '0;
      req     <= '0;
    end else begin
      valid_o <= 1'b0;
      wreg_o  <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (valid_i) begin
            if (is_md) begin
              state    <= BUSY;
              cnt      <= '0;
              hi       <= '0;
              lo       <= is_div ? mag_a : mag_b;
              dvs      <= is_div ? mag_b : mag_a;
              req.fn   <= op_i[2:0];
              req.sa   <= sa_in;
              req.sb   <= sb_in;
              req.bz   <= (reg2_i == '0);
              req.wd   <= wd_i;
              req.wreg <= wreg_i && (wd_i != '0);
            end else begin
              valid_o <= 1'b1;
              wdata_o <= alu_res;
              wd_o    <= wd_i;
              wreg_o  <= wreg_i && (wd_i != '0);
            end
          end
          BUSY: begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + 1'b1;
            if (cnt == SHW'(XLEN-1)) state <= DONE;
          end
          DONE: begin
            valid_o <= 1'b1;
            wdata_o <= md_res;
            wd_o    <= req.wd;
            wreg_o  <= req.wreg;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
